// File: rtl/bulbul_pkg.sv
// Shared types for the bulbul RV32 front end: opcodes, type indices,
// decoded bundle and decoder occupancy states.
package bulbul_pkg;

   localparam int NTYPE  = 11;
   localparam int PC_MAX = 32;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      T_R, T_I, T_LOAD, T_STORE, T_BRANCH, T_JALR,
      T_JAL, T_LUI, T_AUIPC, T_FENCE, T_SYSTEM
   } instr_type_e;

   typedef struct packed {
      logic [NTYPE-1:0]  typ;
      logic              illegal;
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [PC_MAX-1:0] pc;
   } decoded_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

endpackage

// File: rtl/type_decode_pipe_if.sv
// Upstream/downstream handshake bundle of the type decoder.
// illegal_cnt_o exists only with TYPE_DECODE_ILLEGAL_CNT_EN.
interface type_decode_pipe_if #(
   parameter int ILEN  = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) ();
   logic             valid_i;
   logic             ready_o;
   logic [ILEN-1:0]  instr_i;
   logic [PC_W-1:0]  pc_i;
   logic             valid_o;
   logic             ready_i;
   logic [10:0]      type_o;
   logic             illegal_o;
   logic [4:0]       rd_o;
   logic [4:0]       rs1_o;
   logic [4:0]       rs2_o;
   logic [2:0]       funct3_o;
   logic [6:0]       funct7_o;
   logic [PC_W-1:0]  pc_o;
`ifdef TYPE_DECODE_ILLEGAL_CNT_EN
   logic [CNT_W-1:0] illegal_cnt_o;

   modport slave (
      input  valid_i, instr_i, pc_i, ready_i,
      output ready_o, valid_o, type_o, illegal_o,
      output rd_o, rs1_o, rs2_o, funct3_o, funct7_o,
      output pc_o, illegal_cnt_o
   );
   modport master (
      output valid_i, instr_i, pc_i, ready_i,
      input  ready_o, valid_o, type_o, illegal_o,
      input  rd_o, rs1_o, rs2_o, funct3_o, funct7_o,
      input  pc_o, illegal_cnt_o
   );
`else
   modport slave (
      input  valid_i, instr_i, pc_i, ready_i,
      output ready_o, valid_o, type_o, illegal_o,
      output rd_o, rs1_o, rs2_o, funct3_o, funct7_o,
      output pc_o
   );
   modport master (
      output valid_i, instr_i, pc_i, ready_i,
      input  ready_o, valid_o, type_o, illegal_o,
      input  rd_o, rs1_o, rs2_o, funct3_o, funct7_o,
      input  pc_o
   );
`endif

   if (CNT_W < 1) begin : g_cnt_chk
      $error("CNT_W must be at least 1");
   end

endinterface

// File: rtl/type_decode_comb.sv
// Pure combinational RV32 opcode classifier producing a decoded_t.
module type_decode_comb
   import bulbul_pkg::*;
#(
   parameter bit EXT_EN = 1'b1,
   parameter int PC_W   = 32
) (
   input  logic [31:0]   instr,
   input  logic [PC_W-1:0] pc,
   output decoded_t      dec
);

   logic [6:0]       opc;
   logic [NTYPE-1:0] hit;

   assign opc = instr[6:0];

   // every listed opcode ends in 2'b11, so a bad
   // low pair can never match and falls to illegal
   always_comb begin
      hit = '0;
      unique case (1'b1)
         opc == OPC_R:      hit[T_R]      = 1'b1;
         opc == OPC_I:      hit[T_I]      = 1'b1;
         opc == OPC_LOAD:   hit[T_LOAD]   = 1'b1;
         opc == OPC_STORE:  hit[T_STORE]  = 1'b1;
         opc == OPC_BRANCH: hit[T_BRANCH] = 1'b1;
         opc == OPC_JALR:   hit[T_JALR]   = (instr[14:12] == 3'b000);
         opc == OPC_JAL:    hit[T_JAL]    = 1'b1;
         opc == OPC_LUI:    hit[T_LUI]    = 1'b1;
         opc == OPC_AUIPC:  hit[T_AUIPC]  = EXT_EN;
         opc == OPC_FENCE:  hit[T_FENCE]  = EXT_EN;
         opc == OPC_SYSTEM: hit[T_SYSTEM] = EXT_EN;
         default: hit = '0;
      endcase
   end

   always_comb begin
      dec         = '0;
      dec.typ     = hit;
      dec.illegal = (hit == '0);
      dec.rd      = instr[11:7];
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.funct3  = instr[14:12];
      dec.funct7  = instr[31:25];
      dec.pc      = PC_MAX'(pc);
   end

endmodule

// File: rtl/type_decode_pipe.sv
// Registered instruction-type decoder with a two-entry skid buffer.
// Optional illegal counter: define TYPE_DECODE_ILLEGAL_CNT_EN.
module type_decode_pipe
   import bulbul_pkg::*;
#(
   parameter int ILEN   = 32,
   parameter int PC_W   = 32,
   parameter bit EXT_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input logic clk_i,
   input logic rst_ni,
   input logic flush_i,
   type_decode_pipe_if.slave bus
);

   if (ILEN != 32) begin : g_ilen_chk
      $error("ILEN must be 32");
   end
   if (PC_W > PC_MAX || CNT_W < 1) begin : g_w_chk
      $error("PC_W or CNT_W out of range");
   end

   occ_e     state_q;
   decoded_t head_q;
   decoded_t tail_q;
   decoded_t dec;
   logic     acc;
   logic     pop;

   type_decode_comb #(
      .EXT_EN (EXT_EN),
      .PC_W   (PC_W)
   ) u_comb (
      .instr (bus.instr_i),
      .pc    (bus.pc_i),
      .dec   (dec)
   );

   assign acc = bus.valid_i && (state_q != FULL);
   assign pop = bus.ready_i && (state_q != EMPTY);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else if (flush_i) begin
         state_q <= EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (acc) begin
               head_q  <= dec;
               state_q <= ONE;
            end
            ONE: begin
               if (acc && !pop) begin
                  tail_q  <= dec;
                  state_q <= FULL;
               end else if (acc && pop) begin
                  head_q  <= dec;
               end else if (pop) begin
                  state_q <= EMPTY;
               end
            end
            FULL: if (pop) begin
               head_q  <= tail_q;
               state_q <= ONE;
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign bus.ready_o   = (state_q != FULL);
   assign bus.valid_o   = (state_q != EMPTY);
   assign bus.type_o    = head_q.typ;
   assign bus.illegal_o = head_q.illegal;
   assign bus.rd_o      = head_q.rd;
   assign bus.rs1_o     = head_q.rs1;
   assign bus.rs2_o     = head_q.rs2;
   assign bus.funct3_o  = head_q.funct3;
   assign bus.funct7_o  = head_q.funct7;
   assign bus.pc_o      = head_q.pc[PC_W-1:0];

`ifdef TYPE_DECODE_ILLEGAL_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // saturating; flush leaves it alone
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (acc && !flush_i && dec.illegal && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.illegal_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_type_decode_pipe.sv
// Directed bench for type_decode_pipe: EXT_EN=1/CNT_W=16 and
// EXT_EN=0/CNT_W=2 instances driven in lockstep against a queue model.
module tb_type_decode_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        valid = 1'b0;
   logic        rdy = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   type_decode_pipe_if #(.CNT_W(16)) bus0 ();
   type_decode_pipe_if #(.CNT_W(2))  bus1 ();

   assign bus0.valid_i = valid;
   assign bus0.instr_i = instr;
   assign bus0.pc_i    = pc;
   assign bus0.ready_i = rdy;
   assign bus1.valid_i = valid;
   assign bus1.instr_i = instr;
   assign bus1.pc_i    = pc;
   assign bus1.ready_i = rdy;

   type_decode_pipe #(.EXT_EN(1'b1), .CNT_W(16)) u0 (
      .clk_i (clk), .rst_ni (rst_n), .flush_i (flush), .bus (bus0)
   );
   type_decode_pipe #(.EXT_EN(1'b0), .CNT_W(2)) u1 (
      .clk_i (clk), .rst_ni (rst_n), .flush_i (flush), .bus (bus1)
   );

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];
   int   cnt0 = 0;
   int   cnt1 = 0;
   bit   m_acc, m_pop;
   logic [11:0] m_d;

   // {illegal, one-hot type}; type index 0 = R ... 10 = SYSTEM
   function automatic logic [11:0] ref_dec(logic [31:0] w, bit ext);
      int idx;
      logic [10:0] one;
      idx = -1;
      case (w[6:0])
         7'h33: idx = 0;
         7'h13: idx = 1;
         7'h03: idx = 2;
         7'h23: idx = 3;
         7'h63: idx = 4;
         7'h67: idx = (w[14:12] == 3'd0) ? 5 : -1;
         7'h6F: idx = 6;
         7'h37: idx = 7;
         7'h17: idx = ext ? 8 : -1;
         7'h0F: idx = ext ? 9 : -1;
         7'h73: idx = ext ? 10 : -1;
         default: idx = -1;
      endcase
      if (w[1:0] != 2'b11) idx = -1;
      if (idx < 0) return {1'b1, 11'b0};
      one = 11'd1;
      return {1'b0, one << idx};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         cnt0 = 0;
         cnt1 = 0;
      end else if (flush) begin
         mq.delete();
      end else begin
         m_acc = valid && (mq.size() < 2);
         m_pop = rdy && (mq.size() != 0);
         if (m_pop) void'(mq.pop_front());
         if (m_acc) begin
            mq.push_back('{ins: instr, pc: pc});
            m_d = ref_dec(instr, 1'b1);
            if (m_d[11] && cnt0 < 65535) cnt0++;
            m_d = ref_dec(instr, 1'b0);
            if (m_d[11] && cnt1 < 3) cnt1++;
         end
      end
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   task automatic cmp(input int d, input logic v, input logic r,
                      input logic [10:0] t, input logic il,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] p,
                      input logic [15:0] c);
      logic [11:0] e;
      string u;
      u = $sformatf("u%0d", d);
      chk({u, " valid_o"}, 64'(v), 64'(mq.size() != 0));
      chk({u, " ready_o"}, 64'(r), 64'(mq.size() < 2));
      if (mq.size() != 0) begin
         e = ref_dec(mq[0].ins, d == 0);
         chk({u, " type_o"}, 64'(t), 64'(e[10:0]));
         chk({u, " illegal_o"}, 64'(il), 64'(e[11]));
         chk({u, " onehot"}, 64'($countones({il, t})), 64'd1);
         chk({u, " rd"}, 64'(rd), 64'(mq[0].ins[11:7]));
         chk({u, " rs1"}, 64'(rs1), 64'(mq[0].ins[19:15]));
         chk({u, " rs2"}, 64'(rs2), 64'(mq[0].ins[24:20]));
         chk({u, " funct3"}, 64'(f3), 64'(mq[0].ins[14:12]));
         chk({u, " funct7"}, 64'(f7), 64'(mq[0].ins[31:25]));
         chk({u, " pc_o"}, 64'(p), 64'(mq[0].pc));
      end
`ifdef TYPE_DECODE_ILLEGAL_CNT_EN
      chk({u, " illegal_cnt"}, 64'(c), 64'((d == 0) ? cnt0 : cnt1));
`endif
   endtask

   logic [15:0] c0, c1;
`ifdef TYPE_DECODE_ILLEGAL_CNT_EN
   assign c0 = bus0.illegal_cnt_o;
   assign c1 = 16'(bus1.illegal_cnt_o);
`else
   assign c0 = '0;
   assign c1 = '0;
`endif

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp(0, bus0.valid_o, bus0.ready_o, bus0.type_o, bus0.illegal_o,
             bus0.rd_o, bus0.rs1_o, bus0.rs2_o, bus0.funct3_o,
             bus0.funct7_o, bus0.pc_o, c0);
         cmp(1, bus1.valid_o, bus1.ready_o, bus1.type_o, bus1.illegal_o,
             bus1.rd_o, bus1.rs1_o, bus1.rs2_o, bus1.funct3_o,
             bus1.funct7_o, bus1.pc_o, c1);
      end
   end

   bit acc_pend;

   task automatic wait_acc();
      bit done;
      done = 1'b0;
      acc_pend = (mq.size() < 2) && !flush;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         if (acc_pend) begin
            done = 1'b1;
            break;
         end
         #1;
         acc_pend = (mq.size() < 2) && !flush;
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL accept timeout: got none want accept");
      end
      #1 valid = 1'b0;
   endtask

   task automatic drive(input logic [31:0] w, input logic [31:0] p);
      @(negedge clk);
      #1;
      valid = 1'b1;
      instr = w;
      pc    = p;
   endtask

   task automatic send(input logic [31:0] w, input logic [31:0] p);
      drive(w, p);
      wait_acc();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] mix [8] = '{
      32'h00B50533, 32'h00100093, 32'h0000A103, 32'h0020A023,
      32'h00208463, 32'h000080E7, 32'h008000EF, 32'h123452B7
   };
   logic [31:0] bad [5] = '{
      32'h00000000, 32'h00000001, 32'h0000007F,
      32'h000010E7, 32'h0000002B
   };

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst valid_o", 64'(bus0.valid_o), 64'd0);
      chk("rst ready_o", 64'(bus0.ready_o), 64'd1);
      chk("rst type_o", 64'(bus0.type_o), 64'd0);
      chk("rst pc_o", 64'(bus0.pc_o), 64'd0);
      chk("rst rd_o", 64'(bus1.rd_o), 64'd0);
      chk("rst illegal_o", 64'(bus1.illegal_o), 64'd0);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // single add
      rdy = 1'b1;
      send(32'h00B50533, 32'h0000_0040);
      @(negedge clk);
      chk("add valid_o", 64'(bus0.valid_o), 64'd1);
      chk("add type_o", 64'(bus0.type_o), 64'h001);
      chk("add rd", 64'(bus0.rd_o), 64'd10);
      chk("add rs1", 64'(bus0.rs1_o), 64'd10);
      chk("add rs2", 64'(bus0.rs2_o), 64'd11);
      @(negedge clk);
      chk("add gone", 64'(bus0.valid_o), 64'd0);

      // back-to-back stream
      for (int i = 0; i < 8; i++) send(mix[i], 32'h100 + 32'(i * 4));
      idle(3);

      // backpressure: two taken, third held
      rdy = 1'b0;
      send(32'h00C58633, 32'h200);
      send(32'h00400113, 32'h204);
      drive(32'h0040A183, 32'h208);
      idle(3);
      chk("bp ready_o", 64'(bus0.ready_o), 64'd0);
      chk("bp head pc", 64'(bus0.pc_o), 64'h200);
      #1 rdy = 1'b1;
      wait_acc();
      idle(4);

      // ext types and illegal counting
      send(32'h00000073, 32'h300);
      @(negedge clk);
      chk("ecall u1 illegal", 64'(bus1.illegal_o), 64'd1);
      chk("ecall u1 type", 64'(bus1.type_o), 64'd0);
      chk("ecall u0 type", 64'(bus0.type_o), 64'h400);
`ifdef TYPE_DECODE_ILLEGAL_CNT_EN
      chk("cnt after ecall", 64'(bus1.illegal_cnt_o), 64'd1);
`endif
      send(32'h00000000, 32'h304);
      @(negedge clk);
      chk("zero u0 illegal", 64'(bus0.illegal_o), 64'd1);
`ifdef TYPE_DECODE_ILLEGAL_CNT_EN
      chk("cnt after zero", 64'(bus1.illegal_cnt_o), 64'd2);
`endif
      send(32'h00000297, 32'h308);
      send(32'h0000000F, 32'h30C);
      idle(3);

      // flush while full with an incoming instruction
      rdy = 1'b0;
      send(32'h00000013, 32'h400);
      send(32'h00000037, 32'h404);
      @(negedge clk);
      #1;
      valid = 1'b1;
      instr = 32'hFFFFFFFF;
      pc    = 32'h408;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("flush valid_o", 64'(bus0.valid_o), 64'd0);
      chk("flush ready_o", 64'(bus0.ready_o), 64'd1);
      rdy = 1'b1;
      idle(3);

      // saturation on the 2-bit counter
      for (int i = 0; i < 5; i++) send(bad[i], 32'h500 + 32'(i * 4));
      idle(3);
`ifdef TYPE_DECODE_ILLEGAL_CNT_EN
      chk("cnt sat u1", 64'(bus1.illegal_cnt_o), 64'd3);
      chk("cnt u0", 64'(bus0.illegal_cnt_o), 64'd6);
`endif

      // asynchronous reset mid-transfer
      rdy = 1'b0;
      send(32'h00B50533, 32'h600);
      send(32'h00100093, 32'h604);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst valid_o", 64'(bus0.valid_o), 64'd0);
      chk("arst ready_o", 64'(bus0.ready_o), 64'd1);
      chk("arst type_o", 64'(bus0.type_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rdy = 1'b1;
      idle(3);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/type_decode_pipe.md
# type_decode_pipe

Registered, flow-controlled instruction-type decoder for the bulbul RV32 core, sitting between fetch and the register-read/execute stage. It classifies each 32-bit instruction into a one-hot type vector and flags illegal encodings. It extracts the register/function fields and carries the PC alongside. A two-entry skid buffer decouples the valid/ready handshakes on both sides, with flush support for branch redirects.

## Interface
- `ILEN`, 32, instruction width; only 32 is legal, checked by elaboration assertion.
- `PC_W`, 32, program-counter width carried through.
- `EXT_EN`, 1, when 1 AUIPC, FENCE and SYSTEM decode as legal types; when 0 they decode as illegal.
- `CNT_W`, 16, width of the illegal-instruction counter.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  discard all buffered entries.
- `valid_i`  in  1  upstream instruction valid.
- `ready_o`  out  1  decoder can accept.
- `instr_i`  in  ILEN  instruction word.
- `pc_i`  in  PC_W  instruction address.
- `valid_o`  out  1  decoded entry valid.
- `ready_i`  in  1  downstream accepts.
- `type_o`  out  11  one-hot, bit order: R, I, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC, FENCE, SYSTEM.
- `illegal_o`  out  1  entry is illegal; `type_o` is all-zero for such an entry.
- `rd_o`, `rs1_o`, `rs2_o`  out  5 each  fields instr[11:7], [19:15], [24:20].
- `funct3_o`  out  3  field instr[14:12].
- `funct7_o`  out  7  field instr[31:25].
- `pc_o`  out  PC_W  carried PC.
- `illegal_cnt_o`  out  CNT_W  illegal counter; present only with the macro.

## Operation
- Decode is combinational on `instr_i`; the result is written into the buffer on accept (`valid_i && ready_o`).
- Opcodes:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - JALR = 1100111 with funct3 = 000
  - JAL = 1101111
  - LUI = 0110111
  - AUIPC = 0010111
  - FENCE = 0001111
  - SYSTEM = 1110011
- Any other encoding is illegal. Also illegal: instr[1:0] != 11, JALR with funct3 != 000, and the EXT types when `EXT_EN` = 0.
- Exactly one of `type_o` bits or `illegal_o` is set for every valid entry; never zero, never more than one.
- Buffer occupancy FSM: EMPTY, ONE, FULL.
  - EMPTY: accept → ONE.
  - ONE: accept without pop → FULL. Pop without accept → EMPTY. Accept with pop → ONE.
  - FULL: pop → ONE. No accept is possible in FULL.
- FIFO order: the output register is the head; the skid register is the tail.
- `ready_o` = (state != FULL). It is derived from registered state only, with no combinational path from `ready_i`.
- `valid_o` = (state != EMPTY).
- Output fields are driven from the head register and are stable while `valid_o && !ready_i`.
- `flush_i`: next state is EMPTY. Flush overrides a same-cycle accept and pop; the incoming instruction is dropped and not counted.

## Timing
- Latency: one cycle from accept to `valid_o`.
- Throughput: one instruction per cycle while `ready_i` = 1.
- Reset values:
  - state EMPTY, so `valid_o` = 0 and `ready_o` = 1.
  - `type_o`, `illegal_o`, all fields, `pc_o` and `illegal_cnt_o` all 0.
- Reset asserted mid-transfer clears all entries immediately, asynchronously.
- Backpressure: a full stall takes 2 accepted entries, then `ready_o` falls the following cycle.

## Configuration
- Macro: `TYPE_DECODE_ILLEGAL_CNT_EN`.
- Defined:
  - `illegal_cnt_o` exists and increments by 1 on each accepted illegal instruction.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - It is not cleared by flush; reset clears it.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `bulbul_pkg` holds:
  - the opcode constants (`OPC_R`, `OPC_LOAD`, ...);
  - the `instr_type_e` bit-index enum;
  - the `decoded_t` packed struct (type, illegal, rd, rs1, rs2, funct3, funct7, pc).
- One sub-module, `type_decode_comb`: pure combinational opcode → `decoded_t`. The parent owns the skid buffer, FSM and counter.

## Test plan
- Reset, then a single 0x00B50533 (add) with `ready_i` = 1 → next cycle `valid_o` = 1, `type_o` R bit, rd = 10, rs1 = 10, rs2 = 11; `valid_o` = 0 the cycle after.
- Back-to-back stream of 8 mixed legal types with `ready_i` held 1 → 8 consecutive valid outputs in order, one per cycle, correct one-hot each.
- Hold `ready_i` = 0 while sending 3 instructions → first two accepted, `ready_o` = 0, third held upstream. Raise `ready_i` → all three emerge in order with no duplication.
- `EXT_EN` = 0, send 0x00000073 (ecall) → `illegal_o` = 1, `type_o` = 0. With the macro defined, `illegal_cnt_o` = 1. Also send 0x00000000 → count 2.
- FULL state with `flush_i` and `valid_i` both high → next cycle `valid_o` = 0, `ready_o` = 1, and the flushed and incoming entries never appear.
- `CNT_W` = 2, send 5 illegal instructions → `illegal_cnt_o` saturates at 3.
